// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one time-shared full adder walks the operands
// LSB first, one bit per clock, and reports sum, carry-out and signed overflow.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | one operand bit per edge through the shared full adder
// DONE  | single-cycle done pulse, then back to IDLE unconditionally

module serial_add_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output wire  s_o,
  output wire  c_o
);
  wire p;
  wire g;
  wire t;

  xor u_x1 (p, a_i, b_i);
  xor u_x2 (s_o, p, c_i);
  and u_a1 (g, a_i, b_i);
  and u_a2 (t, p, c_i);
  or  u_o1 (c_o, g, t);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  wire              fa_s;
  wire              fa_c;

  // The only adder in the block; operands are presented one bit at a time.
  serial_add_fa u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // State and datapath registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and datapath update; everything holds unless the state acts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_s;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = fa_c;
        cnt_d            = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry entering the top bit at this point.
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: fixed vectors, random adds, back-to-back starts,
// mid-run reset and an exhaustive sweep of a 4-bit instance.

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: plain integer addition; overflow = same-sign operands, different-sign result.
  function automatic void model(input int w, input int a, input int b, input int c,
                                output int s, output int co, output int ov);
    int total, sa, sb, ss;
    total = a + b + c;
    s     = total & ((1 << w) - 1);
    co    = (total >> w) & 1;
    sa    = (a >> (w - 1)) & 1;
    sb    = (b >> (w - 1)) & 1;
    ss    = (s >> (w - 1)) & 1;
    ov    = ((sa == sb) && (ss != sa)) ? 1 : 0;
  endfunction

  function automatic int get_busy(input int w);
    return (w == 8) ? int'(busy8) : int'(busy4);
  endfunction

  function automatic int get_done(input int w);
    return (w == 8) ? int'(done8) : int'(done4);
  endfunction

  task automatic scramble(input int w);
    if (w == 8) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
    end else begin
      a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom_range(0, 1));
    end
  endtask

  // Starts one addition from an IDLE cycle, scrambles the operand inputs while
  // busy, checks latency, busy span, result and done pulse width, and returns
  // in the first IDLE cycle after done.
  task automatic run_add(input int w, input int a, input int b, input int c,
                         input int es, input int eco, input int eov, input string tag);
    int n, busy_cnt, rs, rco, rov;
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = c[0]; start8 = 1'b1;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; cin4 = c[0]; start4 = 1'b1;
    end
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
    n = 1;
    busy_cnt = 0;
    forever begin
      scramble(w);
      if (get_busy(w) != 0) busy_cnt++;
      if (get_done(w) != 0 || n >= 40) break;
      @(negedge clk);
      n++;
    end
    rs  = (w == 8) ? int'(sum8)  : int'(sum4);
    rco = (w == 8) ? int'(cout8) : int'(cout4);
    rov = (w == 8) ? int'(ovf8)  : int'(ovf4);
    chk({tag, ":latency"}, n, w + 1);
    chk({tag, ":busy_cycles"}, busy_cnt, w + 1);
    chk({tag, ":sum"}, rs, es);
    chk({tag, ":cout"}, rco, eco);
    chk({tag, ":ovf"}, rov, eov);
    @(negedge clk);
    chk({tag, ":done_width"}, get_done(w), 0);
    chk({tag, ":busy_after"}, get_busy(w), 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int es, eco, eov, seen, dcount;
    int ra[3], rb[3], rc[3];
    logic expd;

    vt[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

    // Reset with start also high: reset must win.
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
    start4 = 1'b1; a4 = 4'h9;  b4 = 4'h6;  cin4 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:busy8", int'(busy8), 0);
    chk("rst:done8", int'(done8), 0);
    chk("rst:sum8",  int'(sum8), 0);
    chk("rst:cout8", int'(cout8), 0);
    chk("rst:ovf8",  int'(ovf8), 0);
    chk("rst:busy4", int'(busy4), 0);
    rst = 1'b0;
    start8 = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle:busy8", int'(busy8), 0);
    chk("idle:sum8",  int'(sum8), 0);

    for (int i = 0; i < 6; i++) begin
      run_add(8, int'(vt[i].a), int'(vt[i].b), int'(vt[i].cin),
              int'(vt[i].s), int'(vt[i].co), int'(vt[i].ov), $sformatf("vec%0d", i));
    end

    // Result must persist through idle cycles.
    repeat (4) @(negedge clk);
    chk("hold:sum8",  int'(sum8), int'(vt[5].s));
    chk("hold:cout8", int'(cout8), int'(vt[5].co));
    chk("hold:ovf8",  int'(ovf8), int'(vt[5].ov));

    for (int i = 0; i < 40; i++) begin
      int ra0, rb0, rc0;
      ra0 = int'($urandom_range(0, 255));
      rb0 = int'($urandom_range(0, 255));
      rc0 = int'($urandom_range(0, 1));
      model(8, ra0, rb0, rc0, es, eco, eov);
      run_add(8, ra0, rb0, rc0, es, eco, eov, $sformatf("rnd%0d", i));
    end

    // start held high with operands changing every cycle: accepts at 0, 10, 20.
    dcount = 0;
    for (int i = 0; i <= 32; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      start8 = (i <= 20);
      if ((i % 10) == 0 && i <= 20) begin
        ra[i / 10] = int'(a8); rb[i / 10] = int'(b8); rc[i / 10] = int'(cin8);
      end
      @(negedge clk);
      expd = ((i % 10) == 8) && (i <= 28);
      if (done8) dcount++;
      chk($sformatf("b2b:done@%0d", i), int'(done8), int'(expd));
      if (expd) begin
        model(8, ra[i / 10], rb[i / 10], rc[i / 10], es, eco, eov);
        chk($sformatf("b2b:sum%0d", i / 10), int'(sum8), es);
        chk($sformatf("b2b:cout%0d", i / 10), int'(cout8), eco);
        chk($sformatf("b2b:ovf%0d", i / 10), int'(ovf8), eov);
      end
    end
    start8 = 1'b0;
    chk("b2b:done_count", dcount, 3);

    // Reset asserted at the 4th RUN edge aborts the addition.
    a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort:busy_before", int'(busy8), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort:busy", int'(busy8), 0);
    chk("abort:sum",  int'(sum8), 0);
    chk("abort:done", int'(done8), 0);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    chk("abort:no_done", seen, 0);
    model(8, 8'hC3, 8'h4E, 0, es, eco, eov);
    run_add(8, 8'hC3, 8'h4E, 0, es, eco, eov, "abort:next");

    // Exhaustive 4-bit sweep, back-to-back.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          model(4, x, y, c, es, eco, eov);
          run_add(4, x, y, c, es, eco, eov, $sformatf("ex4_%0d_%0d_%0d", x, y, c));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; accepted only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on the accepted start edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on the accepted start edge.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in, captured on the accepted start edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result register.
REQ-011 The block SHALL have port cout, output, 1 bit: carry-out of bit WIDTH-1.
REQ-012 The block SHALL have port ovf, output, 1 bit: signed overflow, defined as (carry into bit WIDTH-1) XOR cout.

Function
REQ-013 The block SHALL contain exactly one 1-bit full-adder instance (gate-level xor/and/or), time-shared across all bit positions.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 at edge E0 SHALL do all of the following: load a and b into operand shift registers, load cin into the carry flop, clear the bit counter, clear sum, cout and ovf, and move to RUN.
REQ-016 In IDLE with start=0, all registers SHALL hold their values.
REQ-017 In RUN, each edge Ek (k=1..WIDTH) SHALL process bit k-1, LSB first, through the full adder.
REQ-018 On each RUN edge, the adder sum bit SHALL shift into sum at the MSB, with sum shifting right.
REQ-019 On each RUN edge, the carry flop SHALL take the adder carry, both operand registers SHALL shift right, and the counter SHALL increment.
REQ-020 On edge EWIDTH, the block SHALL write cout = final carry and ovf = (carry entering the last bit) XOR (final carry), and SHALL move to DONE.
REQ-021 After edge EWIDTH, sum SHALL equal (a+b+cin) mod 2^WIDTH and cout SHALL equal bit WIDTH of a+b+cin.
REQ-022 done SHALL be high only during the cycle in DONE; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-023 Latency SHALL be fixed: done is high in the cycle following edge EWIDTH, i.e. WIDTH+1 cycles after the start cycle.
REQ-024 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-025 start SHALL be ignored in RUN and DONE; it is not queued, and changes on a, b and cin during busy SHALL NOT affect the result.
REQ-026 The earliest accepted back-to-back start SHALL be in the first IDLE cycle after done, giving a throughput of one addition per WIDTH+2 cycles.
REQ-027 sum, cout and ovf SHALL hold the last result from DONE until the next accepted start clears them.
REQ-028 With WIDTH=1, RUN SHALL last exactly one edge.
REQ-029 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap within RUN.

Reset
REQ-030 rst=1 at any edge SHALL force state IDLE and clear busy, done, sum, cout, ovf, the counter, the carry flop and the operand registers to 0; rst takes priority over start.
REQ-031 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse.
REQ-032 The first start with rst=0 after reset SHALL be accepted normally.

Verification (WIDTH=8 unless stated)
REQ-033 Stimulus a=0x00, b=0x00, cin=0, start=1 for one cycle -> busy for 9 cycles, done on the 9th cycle after start, sum=0x00, cout=0, ovf=0.
REQ-034 Stimulus a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; stimulus a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-035 Stimulus a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0; stimulus a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
REQ-036 Stimulus start held high with a and b changed every cycle during RUN -> exactly one done per WIDTH+2 cycles, and each result uses only the operands captured at acceptance.
REQ-037 Stimulus rst=1 at the 4th RUN edge -> busy=0 and sum=0 on the next cycle, no done pulse, and the next start produces a correct result.
REQ-038 Exhaustive check at WIDTH=4, all a, b and cin -> {cout,sum} equals a+b+cin, ovf matches signed overflow, and done appears 5 cycles after each start.
